// File: rtl/alu_op_sequencer_if.sv
// Bus-side signal bundle between the instruction source and the ALU sequencer.
// master drives the instruction request; slave is the sequencer driving datapath controls.
interface alu_op_sequencer_if;
  logic        start;
  logic [4:0]  opcode;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic [15:0] Rout;
  logic [15:0] Rin;
  logic        Yin;
  logic        Zhighin;
  logic        Zlowin;
  logic        Zhighout;
  logic        Zlowout;
  logic        HIin;
  logic        LOin;
  logic [4:0]  op;
  logic        busy;
  logic        done;

  modport master (
    output start, opcode, ra, rb, rc,
    input  Rout, Rin, Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin, op, busy, done
  );

  modport slave (
    input  start, opcode, ra, rb, rc,
    output Rout, Rin, Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin, op, busy, done
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one register-to-register ALU instruction through the bus T-states.
// Controls are registered from the next-state decode so they line up with the state register.
module alu_op_sequencer #(
  parameter logic [4:0] OP_MUL = 5'b01111,
  parameter logic [4:0] OP_DIV = 5'b10000,
  parameter logic [4:0] OP_NEG = 5'b10001,
  parameter logic [4:0] OP_NOT = 5'b10010
) (
  input  logic               Clock,
  input  logic               clear,
  alu_op_sequencer_if.slave  bus
);

  localparam int unsigned OPW  = 5;
  localparam int unsigned RW   = 4;
  localparam int unsigned NREG = 16;
  localparam logic [NREG-1:0] ONE_HOT0 = NREG'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_T_Y, S_T_ALU, S_T_LO, S_T_HI, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [RW-1:0]   ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;

  logic [NREG-1:0] rout_q, rout_d, rin_q, rin_d;
  logic            yin_q, yin_d, zhin_q, zhin_d, zlin_q, zlin_d;
  logic            zhout_q, zhout_d, zlout_q, zlout_d;
  logic            hiin_q, hiin_d, loin_q, loin_d;
  logic [OPW-1:0]  alu_op_q, alu_op_d;
  logic            busy_q, busy_d, done_q, done_d;

  function automatic logic is_unary(input logic [OPW-1:0] o);
    return (o == OP_NEG) || (o == OP_NOT);
  endfunction

  function automatic logic is_hilo(input logic [OPW-1:0] o);
    return (o == OP_MUL) || (o == OP_DIV);
  endfunction

  // Next state and instruction latch
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.opcode;
          ra_d    = bus.ra;
          rb_d    = bus.rb;
          rc_d    = bus.rc;
          state_d = is_unary(bus.opcode) ? S_T_ALU : S_T_Y;
        end
      end
      S_T_Y:   state_d = S_T_ALU;
      S_T_ALU: state_d = S_T_LO;
      S_T_LO:  state_d = is_hilo(op_q) ? S_T_HI : S_DONE;
      S_T_HI:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control decode for the state being entered, so registered outputs match state_q
  always_comb begin
    rout_d   = '0;
    rin_d    = '0;
    yin_d    = 1'b0;
    zhin_d   = 1'b0;
    zlin_d   = 1'b0;
    zhout_d  = 1'b0;
    zlout_d  = 1'b0;
    hiin_d   = 1'b0;
    loin_d   = 1'b0;
    alu_op_d = '0;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    unique case (state_d)
      S_T_Y: begin
        rout_d = ONE_HOT0 << rb_d;
        yin_d  = 1'b1;
      end
      S_T_ALU: begin
        rout_d   = ONE_HOT0 << (is_unary(op_d) ? rb_d : rc_d);
        alu_op_d = op_d;
        zhin_d   = 1'b1;
        zlin_d   = 1'b1;
      end
      S_T_LO: begin
        zlout_d = 1'b1;
        if (is_hilo(op_d)) loin_d = 1'b1;
        else               rin_d  = ONE_HOT0 << ra_d;
      end
      S_T_HI: begin
        zhout_d = 1'b1;
        hiin_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      rout_q   <= '0;
      rin_q    <= '0;
      yin_q    <= 1'b0;
      zhin_q   <= 1'b0;
      zlin_q   <= 1'b0;
      zhout_q  <= 1'b0;
      zlout_q  <= 1'b0;
      hiin_q   <= 1'b0;
      loin_q   <= 1'b0;
      alu_op_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
      rout_q   <= rout_d;
      rin_q    <= rin_d;
      yin_q    <= yin_d;
      zhin_q   <= zhin_d;
      zlin_q   <= zlin_d;
      zhout_q  <= zhout_d;
      zlout_q  <= zlout_d;
      hiin_q   <= hiin_d;
      loin_q   <= loin_d;
      alu_op_q <= alu_op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.Rout     = rout_q;
  assign bus.Rin      = rin_q;
  assign bus.Yin      = yin_q;
  assign bus.Zhighin  = zhin_q;
  assign bus.Zlowin   = zlin_q;
  assign bus.Zhighout = zhout_q;
  assign bus.Zlowout  = zlout_q;
  assign bus.HIin     = hiin_q;
  assign bus.LOin     = loin_q;
  assign bus.op       = alu_op_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; expected control vectors are hand-derived per T-state.
// Vector layout: {Rout, Rin, Yin,Zhighin,Zlowin,Zhighout,Zlowout,HIin,LOin, op, busy, done}.
module tb_alu_op_sequencer;

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;

  localparam logic [45:0] V_IDLE = 46'h0;
  localparam logic [45:0] V_DONE = {16'h0000, 16'h0000, 7'b0000000, 5'h00, 2'b11};

  logic clk;
  logic clear;
  int   vecs;
  int   errs;

  alu_op_sequencer_if bus ();

  alu_op_sequencer dut (
    .Clock (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  logic [45:0] obs;
  assign obs = {bus.Rout, bus.Rin, bus.Yin, bus.Zhighin, bus.Zlowin, bus.Zhighout,
                bus.Zlowout, bus.HIin, bus.LOin, bus.op, bus.busy, bus.done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic s, input logic [4:0] opc,
                           input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    bus.start  = s;
    bus.opcode = opc;
    bus.ra     = a;
    bus.rb     = b;
    bus.rc     = c;
  endtask

  task automatic test_reset();
    set_instr(1'b1, 5'b00110, 4'd1, 4'd2, 4'd3);
    clear = 1'b0;
    repeat (3) cyc();
    vecs++;
    if (obs !== V_IDLE) begin
      $display("FAIL reset_hold: got %h expected %h", obs, V_IDLE);
      errs++;
    end
    @(negedge clk);
    set_instr(1'b0, 5'b00110, 4'd1, 4'd2, 4'd3);
    clear = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      vecs++;
      if (obs !== V_IDLE) begin
        $display("FAIL reset_release_idle[%0d]: got %h expected %h", i, obs, V_IDLE);
        errs++;
      end
    end
  endtask

  task automatic test_binary();
    logic [45:0] ev [5];
    ev = '{ {16'h0004, 16'h0000, 7'b1000000, 5'h00, 2'b10},
            {16'h0008, 16'h0000, 7'b0110000, 5'h06, 2'b10},
            {16'h0000, 16'h0002, 7'b0000100, 5'h00, 2'b10},
            V_DONE, V_IDLE };
    set_instr(1'b1, 5'b00110, 4'd1, 4'd2, 4'd3);
    cyc();
    // Scramble fields after latch; they must not leak into the running instruction.
    set_instr(1'b0, 5'b11111, 4'd9, 4'd10, 4'd11);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      vecs++;
      if (obs !== ev[i]) begin
        $display("FAIL binary_step%0d: got %h expected %h", i, obs, ev[i]);
        errs++;
      end
    end
  endtask

  task automatic test_hilo(input logic [4:0] opc, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [15:0] rout_y, input logic [15:0] rout_alu);
    logic [45:0] ev [6];
    ev = '{ {rout_y,   16'h0000, 7'b1000000, 5'h00, 2'b10},
            {rout_alu, 16'h0000, 7'b0110000, opc,   2'b10},
            {16'h0000, 16'h0000, 7'b0000101, 5'h00, 2'b10},
            {16'h0000, 16'h0000, 7'b0001010, 5'h00, 2'b10},
            V_DONE, V_IDLE };
    set_instr(1'b1, opc, a, b, c);
    cyc();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      vecs++;
      if (obs !== ev[i]) begin
        $display("FAIL hilo_op%h_step%0d: got %h expected %h", opc, i, obs, ev[i]);
        errs++;
      end
    end
  endtask

  task automatic test_unary();
    logic [45:0] ev [4];
    ev = '{ {16'h0040, 16'h0000, 7'b0110000, OP_NEG, 2'b10},
            {16'h0000, 16'h0080, 7'b0000100, 5'h00,  2'b10},
            V_DONE, V_IDLE };
    set_instr(1'b1, OP_NEG, 4'd7, 4'd6, 4'd2);
    cyc();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      vecs++;
      if (obs !== ev[i]) begin
        $display("FAIL unary_neg_step%0d: got %h expected %h", i, obs, ev[i]);
        errs++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [45:0] ev [9];
    ev = '{ {16'h0004, 16'h0000, 7'b1000000, 5'h00,  2'b10},
            {16'h0008, 16'h0000, 7'b0110000, 5'h06,  2'b10},
            {16'h0000, 16'h0002, 7'b0000100, 5'h00,  2'b10},
            V_DONE,
            V_IDLE,
            {16'h4000, 16'h0000, 7'b0110000, OP_NOT, 2'b10},
            {16'h0000, 16'h8000, 7'b0000100, 5'h00,  2'b10},
            V_DONE, V_IDLE };
    set_instr(1'b1, 5'b00110, 4'd1, 4'd2, 4'd3);
    cyc();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) cyc();
      vecs++;
      if (obs !== ev[i]) begin
        $display("FAIL b2b_step%0d: got %h expected %h", i, obs, ev[i]);
        errs++;
      end
      if (i == 1) set_instr(1'b1, OP_NOT, 4'd15, 4'd14, 4'd13);
      if (i == 5) bus.start = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [45:0] alu_v;
    alu_v = {16'h0008, 16'h0000, 7'b0110000, 5'h06, 2'b10};
    set_instr(1'b1, 5'b00110, 4'd1, 4'd2, 4'd3);
    cyc();
    bus.start = 1'b0;
    cyc();
    vecs++;
    if (obs !== alu_v) begin
      $display("FAIL midreset_pre_alu: got %h expected %h", obs, alu_v);
      errs++;
    end
    #2 clear = 1'b0;
    #1;
    vecs++;
    if (obs !== V_IDLE) begin
      $display("FAIL midreset_async_drop: got %h expected %h", obs, V_IDLE);
      errs++;
    end
    @(negedge clk);
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vecs++;
      if (obs !== V_IDLE) begin
        $display("FAIL midreset_after_release[%0d]: got %h expected %h", i, obs, V_IDLE);
        errs++;
      end
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    clear = 1'b0;
    set_instr(1'b0, 5'h00, 4'd0, 4'd0, 4'd0);
    test_reset();
    test_binary();
    test_hilo(OP_MUL, 4'd9, 4'd4, 4'd5, 16'h0010, 16'h0020);
    test_hilo(OP_DIV, 4'd3, 4'd3, 4'd2, 16'h0008, 16'h0004);
    test_unary();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vecs);
    $fatal(1, "watchdog");
  end

endmodule
